// File: rtl/seg_instruction_decode_if.sv
// IF/ID-to-ID/EX bus of the decode stage: IF/ID inputs, WB write port,
// EX hazard info, and the combinational redirect/stall plus registered ID/EX outputs.
interface seg_instruction_decode_if #(
  parameter int LEN         = 32,
  parameter int NB_REG_ADDR = 5
);
  logic [LEN-1:0]         i_instruction;
  logic [LEN-1:0]         i_PC;
  logic                   i_flush;
  logic                   i_reg_write_wb;
  logic [NB_REG_ADDR-1:0] i_write_reg_wb;
  logic [LEN-1:0]         i_write_data_wb;
  logic                   i_mem_read_ex;
  logic [NB_REG_ADDR-1:0] i_rt_ex;

  logic                   o_stall_flag;
  logic                   o_jump;
  logic [LEN-1:0]         o_PC_dir_jump;
  logic [LEN-1:0]         o_PC;
  logic [LEN-1:0]         o_PC_branch;
  logic [LEN-1:0]         o_read_data_1;
  logic [LEN-1:0]         o_read_data_2;
  logic [LEN-1:0]         o_sign_ext;
  logic [NB_REG_ADDR-1:0] o_rs;
  logic [NB_REG_ADDR-1:0] o_rt;
  logic [NB_REG_ADDR-1:0] o_rd;
  logic [4:0]             o_shamt;
  logic [5:0]             o_funct;
  logic                   o_reg_dst;
  logic                   o_alu_src;
  logic                   o_branch;
  logic                   o_mem_read;
  logic                   o_mem_write;
  logic                   o_mem_to_reg;
  logic                   o_reg_write;
  logic [1:0]             o_alu_op;

  modport slave (
    input  i_instruction, i_PC, i_flush, i_reg_write_wb, i_write_reg_wb,
           i_write_data_wb, i_mem_read_ex, i_rt_ex,
    output o_stall_flag, o_jump, o_PC_dir_jump, o_PC, o_PC_branch,
           o_read_data_1, o_read_data_2, o_sign_ext, o_rs, o_rt, o_rd,
           o_shamt, o_funct, o_reg_dst, o_alu_src, o_branch, o_mem_read,
           o_mem_write, o_mem_to_reg, o_reg_write, o_alu_op
  );

  modport master (
    output i_instruction, i_PC, i_flush, i_reg_write_wb, i_write_reg_wb,
           i_write_data_wb, i_mem_read_ex, i_rt_ex,
    input  o_stall_flag, o_jump, o_PC_dir_jump, o_PC, o_PC_branch,
           o_read_data_1, o_read_data_2, o_sign_ext, o_rs, o_rt, o_rd,
           o_shamt, o_funct, o_reg_dst, o_alu_src, o_branch, o_mem_read,
           o_mem_write, o_mem_to_reg, o_reg_write, o_alu_op
  );
endinterface

// File: rtl/seg_instruction_decode.sv
// MIPS ID stage: register file with write-through, reduced-ISA control decode,
// load-use stall detection, in-stage J resolution and the ID/EX pipeline register.
module seg_instruction_decode #(
  parameter int LEN         = 32,
  parameter int NB_REG_ADDR = 5,
  parameter int N_REGS      = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  seg_instruction_decode_if.slave   bus
);
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctl_t;

  logic [LEN-1:0]         regs [N_REGS];
  logic [5:0]             opcode;
  logic [NB_REG_ADDR-1:0] rs, rt, rd;
  logic [LEN-1:0]         sext, rd1, rd2;
  ctl_t                   dec;
  logic                   uses_rs, uses_rt, is_j, stall;

  assign opcode = bus.i_instruction[31:26];
  assign rs     = bus.i_instruction[25:21];
  assign rt     = bus.i_instruction[20:16];
  assign rd     = bus.i_instruction[15:11];
  assign sext   = {{(LEN-16){bus.i_instruction[15]}}, bus.i_instruction[15:0]};

  // Register file; $0 is never written so it always reads back 0.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < N_REGS; i++) regs[i] <= '0;
    end else if (bus.i_reg_write_wb && bus.i_write_reg_wb != '0) begin
      regs[bus.i_write_reg_wb] <= bus.i_write_data_wb;
    end
  end

  // Write-through lets WB and ID share a cycle without a bypass in EX.
  always_comb begin
    rd1 = regs[rs];
    rd2 = regs[rt];
    if (bus.i_reg_write_wb && bus.i_write_reg_wb == rs) rd1 = bus.i_write_data_wb;
    if (bus.i_reg_write_wb && bus.i_write_reg_wb == rt) rd2 = bus.i_write_data_wb;
    if (rs == '0) rd1 = '0;
    if (rt == '0) rd2 = '0;
  end

  always_comb begin
    dec     = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    is_j    = 1'b0;
    unique case (opcode)
      OP_R: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b10;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_LW: begin
        dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
        dec.reg_write = 1'b1;
        uses_rs = 1'b1;
      end
      OP_SW: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_BEQ: begin
        dec.branch = 1'b1; dec.alu_op = 2'b01;
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        uses_rs = 1'b1;
      end
      OP_J: is_j = 1'b1;
      default: ;
    endcase
  end

  // A wrong-path instruction must neither stall fetch nor redirect it.
  assign stall = bus.i_mem_read_ex && (bus.i_rt_ex != '0)
               && ((uses_rs && bus.i_rt_ex == rs) || (uses_rt && bus.i_rt_ex == rt))
               && !bus.i_flush;

  assign bus.o_stall_flag  = stall;
  assign bus.o_jump        = is_j && !bus.i_flush;
  assign bus.o_PC_dir_jump = {bus.i_PC[LEN-1 -: 6], bus.i_instruction[LEN-7:0]};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      bus.o_PC          <= '0;
      bus.o_PC_branch   <= '0;
      bus.o_read_data_1 <= '0;
      bus.o_read_data_2 <= '0;
      bus.o_sign_ext    <= '0;
      bus.o_rs          <= '0;
      bus.o_rt          <= '0;
      bus.o_rd          <= '0;
      bus.o_shamt       <= '0;
      bus.o_funct       <= '0;
      bus.o_reg_dst     <= 1'b0;
      bus.o_alu_src     <= 1'b0;
      bus.o_branch      <= 1'b0;
      bus.o_mem_read    <= 1'b0;
      bus.o_mem_write   <= 1'b0;
      bus.o_mem_to_reg  <= 1'b0;
      bus.o_reg_write   <= 1'b0;
      bus.o_alu_op      <= 2'b00;
    end else begin
      bus.o_PC          <= bus.i_PC;
      bus.o_PC_branch   <= bus.i_PC + sext;
      bus.o_read_data_1 <= rd1;
      bus.o_read_data_2 <= rd2;
      bus.o_sign_ext    <= sext;
      bus.o_rs          <= rs;
      bus.o_rt          <= rt;
      bus.o_rd          <= rd;
      bus.o_shamt       <= bus.i_instruction[10:6];
      bus.o_funct       <= bus.i_instruction[5:0];
      // Flush and stall both inject a bubble; only the control is squashed.
      if (bus.i_flush || stall) begin
        bus.o_reg_dst    <= 1'b0;
        bus.o_alu_src    <= 1'b0;
        bus.o_branch     <= 1'b0;
        bus.o_mem_read   <= 1'b0;
        bus.o_mem_write  <= 1'b0;
        bus.o_mem_to_reg <= 1'b0;
        bus.o_reg_write  <= 1'b0;
        bus.o_alu_op     <= 2'b00;
      end else begin
        bus.o_reg_dst    <= dec.reg_dst;
        bus.o_alu_src    <= dec.alu_src;
        bus.o_branch     <= dec.branch;
        bus.o_mem_read   <= dec.mem_read;
        bus.o_mem_write  <= dec.mem_write;
        bus.o_mem_to_reg <= dec.mem_to_reg;
        bus.o_reg_write  <= dec.reg_write;
        bus.o_alu_op     <= dec.alu_op;
      end
    end
  end
endmodule

// File: tb/tb_seg_instruction_decode.sv
// Directed bench for the ID stage: expected ID/EX contents are queued at drive
// time and popped after the capturing edge; register file mirrored by a model.
module tb_seg_instruction_decode;
  localparam logic [8:0] CTL_R    = 9'b100000110;
  localparam logic [8:0] CTL_LW   = 9'b010101100;
  localparam logic [8:0] CTL_SW   = 9'b010010000;
  localparam logic [8:0] CTL_BEQ  = 9'b001000001;
  localparam logic [8:0] CTL_ADDI = 9'b010000100;
  localparam logic [8:0] CTL_NONE = 9'b000000000;

  typedef struct {
    logic [8:0]  ctl;
    logic [31:0] rd1, rd2, sext, pcb, pc;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  logic [31:0] model [32];
  logic [31:0] v;

  seg_instruction_decode_if #(.LEN(32), .NB_REG_ADDR(5)) bus ();

  seg_instruction_decode #(.LEN(32), .NB_REG_ADDR(5), .N_REGS(32)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic logic [8:0] obs_ctl();
    return {bus.o_reg_dst, bus.o_alu_src, bus.o_branch, bus.o_mem_read,
            bus.o_mem_write, bus.o_mem_to_reg, bus.o_reg_write, bus.o_alu_op};
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] a, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd);
    return {6'b000000, rs, rt, rd, 5'd3, 6'h20};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                       input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic flush,
                      input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                      input logic mr, input logic [4:0] ex_rt,
                      input logic exp_stall, input logic exp_jump, input logic [8:0] exp_ctl);
    exp_t e;
    @(negedge clk);
    bus.i_instruction   = instr;
    bus.i_PC            = pc;
    bus.i_flush         = flush;
    bus.i_reg_write_wb  = we;
    bus.i_write_reg_wb  = wreg;
    bus.i_write_data_wb = wdata;
    bus.i_mem_read_ex   = mr;
    bus.i_rt_ex         = ex_rt;
    e.ctl   = exp_ctl;
    e.rd1   = rf_read(instr[25:21], we, wreg, wdata);
    e.rd2   = rf_read(instr[20:16], we, wreg, wdata);
    e.sext  = {{16{instr[15]}}, instr[15:0]};
    e.pcb   = pc + e.sext;
    e.pc    = pc;
    e.rs    = instr[25:21];
    e.rt    = instr[20:16];
    e.rd    = instr[15:11];
    e.shamt = instr[10:6];
    e.funct = instr[5:0];
    exp_q.push_back(e);
    #1;
    check("stall", 32'(bus.o_stall_flag), 32'(exp_stall));
    check("jump", 32'(bus.o_jump), 32'(exp_jump));
    check("dir_jump", bus.o_PC_dir_jump, {pc[31:26], instr[25:0]});
    @(posedge clk);
    if (we && wreg != 5'd0) model[wreg] = wdata;
    #1;
    e = exp_q.pop_front();
    check("ctl", 32'(obs_ctl()), 32'(e.ctl));
    check("rd1", bus.o_read_data_1, e.rd1);
    check("rd2", bus.o_read_data_2, e.rd2);
    check("sext", bus.o_sign_ext, e.sext);
    check("pc_branch", bus.o_PC_branch, e.pcb);
    check("pc", bus.o_PC, e.pc);
    check("fields", {bus.o_rs, bus.o_rt, bus.o_rd, bus.o_shamt, bus.o_funct, 6'd0},
                    {e.rs, e.rt, e.rd, e.shamt, e.funct, 6'd0});
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    bus.i_instruction = 32'd0; bus.i_PC = 32'd0; bus.i_flush = 1'b0;
    bus.i_reg_write_wb = 1'b0; bus.i_write_reg_wb = 5'd0; bus.i_write_data_wb = 32'd0;
    bus.i_mem_read_ex = 1'b0; bus.i_rt_ex = 5'd0;
    #3;
    check("rst_ctl", 32'(obs_ctl()), 32'd0);
    check("rst_rd1", bus.o_read_data_1, 32'd0);
    check("rst_pc", bus.o_PC, 32'd0);
    @(negedge clk); rst = 1'b1;

    // WB writes $3 while ADD $1,$3,$0 reads it in the same cycle
    step(32'h00600820, 32'h4, 0, 1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 0, 0, CTL_R);
    // $0 write is ignored, with and without a concurrent read
    step(32'h00000820, 32'h5, 0, 1, 5'd0, 32'h00001234, 0, 5'd0, 0, 0, CTL_R);
    step(32'h00000820, 32'h6, 0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0, CTL_R);

    for (int i = 4; i < 10; i++) begin
      v = $urandom;
      step(rtype(5'(i - 1), 5'(i), 5'd1), 32'h20 + i, 0, 1, 5'(i), v, 0, 5'd0, 0, 0, CTL_R);
    end

    // load-use: LW $2 in EX
    step(rtype(5'd3, 5'd2, 5'd1), 32'h30, 0, 0, 5'd0, 0, 1, 5'd2, 1, 0, CTL_NONE);
    step(itype(6'b100011, 5'd2, 5'd7, 16'h0004), 32'h31, 0, 0, 5'd0, 0, 1, 5'd2, 1, 0, CTL_NONE);
    step(itype(6'b001000, 5'd3, 5'd2, 16'h0005), 32'h32, 0, 0, 5'd0, 0, 1, 5'd2, 0, 0, CTL_ADDI);
    step({6'b000010, 26'h0000040}, 32'h100, 0, 0, 5'd0, 0, 1, 5'd2, 0, 1, CTL_NONE);
    step(rtype(5'd3, 5'd0, 5'd1), 32'h33, 0, 0, 5'd0, 0, 1, 5'd0, 0, 0, CTL_R);
    step(rtype(5'd3, 5'd2, 5'd1), 32'h34, 1, 0, 5'd0, 0, 1, 5'd2, 0, 0, CTL_NONE);

    step(itype(6'b000100, 5'd1, 5'd4, 16'hFFFC), 32'h10, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_BEQ);
    step({6'b000010, 26'h0000040}, 32'h200, 1, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_NONE);
    step({6'b000010, 26'h0000040}, 32'h200, 0, 0, 5'd0, 0, 0, 5'd0, 0, 1, CTL_NONE);
    step(itype(6'b101011, 5'd4, 5'd5, 16'h8000), 32'h40, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_SW);
    step(itype(6'b100011, 5'd6, 5'd7, 16'h7FFF), 32'h41, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_LW);
    step(itype(6'b001111, 5'd6, 5'd7, 16'h1234), 32'h42, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_NONE);
    step(itype(6'b001000, 5'd8, 5'd9, 16'h0001), 32'hFFFFFFFF, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_ADDI);

    // mid-run async reset with LW sitting in ID/EX
    step(itype(6'b100011, 5'd5, 5'd7, 16'h0004), 32'h50, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_LW);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_ctl", 32'(obs_ctl()), 32'd0);
    check("mid_rst_pc", bus.o_PC, 32'd0);
    check("mid_rst_rd1", bus.o_read_data_1, 32'd0);
    check("mid_rst_sext", bus.o_sign_ext, 32'd0);
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    @(negedge clk); rst = 1'b1;
    step(rtype(5'd5, 5'd6, 5'd1), 32'h60, 0, 0, 5'd0, 0, 0, 5'd0, 0, 0, CTL_R);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
